if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the ID stage and drives the IF/ID register (instruction + PC).
- Fetches each 32-bit instruction as 4 little-endian bytes over the shared byte-wide memory port.
- Honours the staller hold, memory-port arbitration hold, and jump/branch redirects.

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_byte_assembler.sv | 36 +++
 rtl/if_fetch.sv | 90 +++++++++
 tb/tb_if_fetch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared state encodings and constants for the instruction-fetch stage
package if_fetch_pkg;

   typedef enum logic [2:0] {
      IF_F0  = 3'd0,
      IF_F1  = 3'd1,
      IF_F2  = 3'd2,
      IF_F3  = 3'd3,
      IF_WT  = 3'd4,
      IF_RDY = 3'd5
   } if_state_e;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] NOP_INST  = 32'h0000_0000;
   localparam logic        ENABLE    = 1'b1;
   localparam logic        DISABLE   = 1'b0;

   function automatic logic is_issue_state(input if_state_e s);
      return (s == IF_F0) || (s == IF_F1) || (s == IF_F2) || (s == IF_F3);
   endfunction

endpackage

// File: rtl/if_fetch_byte_assembler.sv
// rtl/if_fetch_byte_assembler.sv - collects fetched bytes into a little-endian instruction word
module if_fetch_byte_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        req,
   input  logic [1:0]  req_idx,
   input  logic [7:0]  din,
   output logic [31:0] word
);

   logic        pending;
   logic [1:0]  idx;
   logic [31:0] buf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         idx     <= 2'd0;
         buf_q   <= 32'h0;
      end else begin
         pending <= req;
         idx     <= req_idx;
         if (pending && !flush)
            buf_q[{idx, 3'b000} +: 8] <= din;
      end
   end

   // Byte 3 arrives in the same cycle the word is handed over, so bypass it in.
   always_comb begin
      word = buf_q;
      if (pending)
         word[{idx, 3'b000} +: 8] = din;
   end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - IF stage: byte-serial instruction fetch feeding the IF/ID register
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jaddr_i,
   input  logic        mem_hold_i,
   input  logic [7:0]  mem_din_i,
   output logic [31:0] mem_a_o,
   output logic        mem_re_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        inst_valid_o
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_d, pc_out_d;
   logic        valid_d;
   logic [31:0] word;
   logic [1:0]  k;
   logic        deliver;

   if_fetch_byte_assembler u_asm (
      .clk     (clk),
      .rst     (rst),
      .flush   (jump_i),
      .req     (mem_re_o),
      .req_idx (k),
      .din     (mem_din_i),
      .word    (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IF_F0;
         pc_q         <= RESET_PC;
         inst_o       <= ZERO_WORD;
         pc_o         <= ZERO_WORD;
         inst_valid_o <= DISABLE;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_o       <= inst_d;
         pc_o         <= pc_out_d;
         inst_valid_o <= valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_o;
      pc_out_d = pc_o;
      valid_d  = inst_valid_o;
      k        = state_q[1:0];
      mem_re_o = is_issue_state(state_q) && !mem_hold_i && !jump_i && !rst;
      mem_a_o  = rst ? ZERO_WORD : pc_q + {30'd0, k};
      deliver  = ((state_q == IF_WT) || (state_q == IF_RDY)) && !stall_i && !jump_i;

      if (jump_i) begin
         // Redirect flushes IF/ID even while ID is stalled.
         pc_d    = jaddr_i;
         state_d = IF_F0;
         inst_d  = NOP_INST;
         valid_d = DISABLE;
      end else if (deliver) begin
         inst_d   = word;
         pc_out_d = pc_q;
         valid_d  = ENABLE;
         pc_d     = pc_q + 32'd4;
         state_d  = IF_F0;
      end else begin
         if (!stall_i) begin
            inst_d  = NOP_INST;
            valid_d = DISABLE;
         end
         if (state_q == IF_WT)
            state_d = IF_RDY;
         else if (mem_re_o)
            state_d = if_state_e'(state_q + 3'd1);
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch against a behavioural model
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst, stall_i, jump_i, mem_hold_i;
   logic [31:0] jaddr_i;
   logic [7:0]  mem_din_i;
   logic [31:0] mem_a_o, inst_o, pc_o;
   logic        mem_re_o, inst_valid_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mem [1024];
   int          m_k;
   logic [31:0] m_pc, m_inst, m_pco;
   logic        m_valid;
   logic        req_q;
   logic [31:0] addr_q;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .jump_i       (jump_i),
      .jaddr_i      (jaddr_i),
      .mem_hold_i   (mem_hold_i),
      .mem_din_i    (mem_din_i),
      .mem_a_o      (mem_a_o),
      .mem_re_o     (mem_re_o),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .inst_valid_o (inst_valid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mem_at(input logic [31:0] a);
      logic [9:0] i;
      i = a[9:0];
      return mem[i];
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {mem_at(a + 32'd3), mem_at(a + 32'd2), mem_at(a + 32'd1), mem_at(a)};
   endfunction

   // One clock: drive inputs, check the request, advance the model, check IF/ID after the edge.
   task automatic cyc(input logic r, input logic s, input logic j,
                      input logic [31:0] ja, input logic h);
      logic exp_re;
      rst        = r;
      stall_i    = s;
      jump_i     = j;
      jaddr_i    = ja;
      mem_hold_i = h;
      mem_din_i  = req_q ? mem_at(addr_q) : 8'($urandom);
      #1;
      exp_re = !r && (m_k < 4) && !h && !j;
      chk("mem_re", {31'd0, mem_re_o}, {31'd0, exp_re});
      if (r)
         chk("mem_a_rst", mem_a_o, 32'h0);
      else if (m_k < 4)
         chk("mem_a", mem_a_o, m_pc + 32'(m_k));
      req_q  = mem_re_o;
      addr_q = mem_a_o;

      if (r) begin
         m_k = 0; m_pc = 32'h0; m_inst = 32'h0; m_pco = 32'h0; m_valid = 1'b0;
      end else if (j) begin
         m_k = 0; m_pc = ja; m_inst = 32'h0; m_valid = 1'b0;
      end else if (m_k == 4 && !s) begin
         m_inst = word_at(m_pc); m_pco = m_pc; m_valid = 1'b1;
         m_pc = m_pc + 32'd4; m_k = 0;
      end else begin
         if (!s) begin
            m_inst = 32'h0; m_valid = 1'b0;
         end
         if (exp_re) m_k++;
      end

      @(posedge clk);
      #1;
      chk("inst", inst_o, m_inst);
      chk("pc", pc_o, m_pco);
      chk("valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jaddr_i = 32'h0;
      mem_hold_i = 1'b0; mem_din_i = 8'h00;
      req_q = 1'b0; addr_q = 32'h0;
      m_k = 0; m_pc = 32'h0; m_inst = 32'h0; m_pco = 32'h0; m_valid = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      run(5);
      chk("tp_first_inst", inst_o, 32'h0010_0513);
      chk("tp_first_pc", pc_o, 32'h0);

      // Memory-port hold for three cycles while in F2.
      run(2);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      run(3);

      // Stall at WT for four cycles, then release.
      run(4);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      run(1);

      // Jump during F2.
      run(2);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
      run(5);

      // Jump while parked in RDY under stall.
      run(4);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
      chk("tp_rdy_flush", {31'd0, inst_valid_o}, 32'h0);
      run(5);

      // Reset asserted in F3.
      run(3);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      run(5);

      // Address wrap past the top of memory.
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      run(5);

      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(19) == 0,
             $urandom, $urandom_range(3) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
